// File: rtl/ball_physics_engine.sv
// Pong ball engine: ball position/velocity, scores and SERVE/PLAY/OVER flow.
// Optional BALL_SPEED_RAMP_EN: each paddle hit speeds |vel_x| up to MAX_VEL.
module ball_physics_engine #(
    parameter int COORD_W     = 16,
    parameter int PADDLE_H    = 100,
    parameter int PADDLE_W    = 13,
    parameter int BALL_SIZE   = 15,
    parameter int WALL_MARGIN = 10,
    parameter int INIT_VEL    = 5,
    parameter int MAX_VEL     = 15,
    parameter int SERVE_TICKS = 60,
    parameter int SCORE_W     = 8,
    parameter int WIN_SCORE   = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               restart,
    input  logic [COORD_W-1:0] dim_x,
    input  logic [COORD_W-1:0] dim_y,
    input  logic [COORD_W-1:0] lpad_x,
    input  logic [COORD_W-1:0] lpad_y,
    input  logic [COORD_W-1:0] rpad_x,
    input  logic [COORD_W-1:0] rpad_y,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [COORD_W-1:0] vel_x,
    output logic [COORD_W-1:0] vel_y,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [1:0]         score_pulse,
    output logic               serve_active,
    output logic               game_over
);
    localparam int EW    = COORD_W + 2;
    localparam int W1    = COORD_W + 1;
    localparam int CNT_W = (SERVE_TICKS < 1) ? 1 : $clog2(SERVE_TICKS + 1);

    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(SERVE_TICKS);
    localparam logic [COORD_W-1:0] V0       = COORD_W'(INIT_VEL);
    localparam logic [SCORE_W-1:0] SMAX     = '1;
    localparam logic [31:0]        WIN      = 32'(WIN_SCORE);
    localparam logic [W1-1:0]      BSZ      = W1'(BALL_SIZE);

    typedef enum logic [1:0] {SERVE, PLAY, OVER} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [COORD_W-1:0] bx_nx, by_nx, vx_nx, vy_nx;
    logic [SCORE_W-1:0] sl_nx, sr_nx, sl_inc, sr_inc;
    logic [1:0]         pulse_nx;

    logic               vx_neg, vx_pos, vy_neg, vy_pos;
    logic               l_zone, r_zone, hit, miss, top, bot;
    logic [W1-1:0]      pad_y;
    logic [COORD_W-1:0] vx_hit, vx_new, vy_new, mid_x, mid_y, cx, cy;
    logic signed [EW-1:0] px, py, lim_x, lim_y;

    assign vx_neg = vel_x[COORD_W-1];
    assign vx_pos = !vel_x[COORD_W-1] && (vel_x != '0);
    assign vy_neg = vel_y[COORD_W-1];
    assign vy_pos = !vel_y[COORD_W-1] && (vel_y != '0);

    assign mid_x = {1'b0, dim_x[COORD_W-1:1]};
    assign mid_y = {1'b0, dim_y[COORD_W-1:1]};

    assign top = (ball_y <= COORD_W'(WALL_MARGIN)) && vy_neg;
    assign bot = ({1'b0, ball_y} + BSZ >= {1'b0, dim_y}) && vy_pos;
    assign vy_new = (top || bot) ? -vel_y : vel_y;

    // Zones are gated by direction, so at most one paddle is considered.
    assign l_zone = vx_neg &&
        ({1'b0, ball_x} < {1'b0, lpad_x} + W1'(PADDLE_W));
    assign r_zone = vx_pos && ({1'b0, ball_x} + BSZ > {1'b0, rpad_x});
    assign pad_y  = l_zone ? {1'b0, lpad_y} : {1'b0, rpad_y};
    assign hit    = ({1'b0, ball_y} + BSZ > pad_y) &&
                    ({1'b0, ball_y} < pad_y + W1'(PADDLE_H));
    assign miss   = (l_zone || r_zone) && !hit;

`ifdef BALL_SPEED_RAMP_EN
    localparam logic [COORD_W-1:0] VMAX = COORD_W'(MAX_VEL);
    logic [COORD_W-1:0] mag, mag_up;
    assign mag    = vx_neg ? -vel_x : vel_x;
    assign mag_up = (mag >= VMAX) ? VMAX : mag + COORD_W'(1);
    assign vx_hit = vx_neg ? mag_up : -mag_up;
`else
    assign vx_hit = -vel_x;
`endif

    assign vx_new = ((l_zone || r_zone) && hit) ? vx_hit : vel_x;

    // Widened signed sum so under/overflow is caught before clamping.
    assign px = $signed({2'b00, ball_x}) +
                $signed({{2{vx_new[COORD_W-1]}}, vx_new});
    assign py = $signed({2'b00, ball_y}) +
                $signed({{2{vy_new[COORD_W-1]}}, vy_new});
    assign lim_x = $signed({2'b00, dim_x} - EW'(1));
    assign lim_y = $signed({2'b00, dim_y} - EW'(1));

    assign cx = px[EW-1] ? '0 :
                (px > lim_x) ? lim_x[COORD_W-1:0] : px[COORD_W-1:0];
    assign cy = py[EW-1] ? '0 :
                (py > lim_y) ? lim_y[COORD_W-1:0] : py[COORD_W-1:0];

    assign sl_inc = (score_l == SMAX) ? score_l : score_l + SCORE_W'(1);
    assign sr_inc = (score_r == SMAX) ? score_r : score_r + SCORE_W'(1);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bx_nx    = ball_x;
        by_nx    = ball_y;
        vx_nx    = vel_x;
        vy_nx    = vel_y;
        sl_nx    = score_l;
        sr_nx    = score_r;
        pulse_nx = 2'b00;
        case (state)
            SERVE: if (frame_tick) begin
                if (cnt != '0) cnt_nx = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) state_nx = PLAY;
            end
            PLAY: if (frame_tick) begin
                unique case (1'b1)
                    miss && r_zone: begin
                        sl_nx    = sl_inc;
                        pulse_nx = 2'b01;
                        vx_nx    = V0;
                        state_nx = (32'(sl_inc) >= WIN) ? OVER : SERVE;
                    end
                    miss && l_zone: begin
                        sr_nx    = sr_inc;
                        pulse_nx = 2'b10;
                        vx_nx    = -V0;
                        state_nx = (32'(sr_inc) >= WIN) ? OVER : SERVE;
                    end
                    default: begin
                        bx_nx = cx;
                        by_nx = cy;
                        vx_nx = vx_new;
                        vy_nx = vy_new;
                    end
                endcase
                if (miss) begin
                    bx_nx  = mid_x;
                    by_nx  = mid_y;
                    vy_nx  = V0;
                    cnt_nx = CNT_INIT;
                end
            end
            OVER: if (restart) begin
                state_nx = SERVE;
                cnt_nx   = CNT_INIT;
                bx_nx    = mid_x;
                by_nx    = mid_y;
                vx_nx    = V0;
                vy_nx    = V0;
                sl_nx    = '0;
                sr_nx    = '0;
            end
            default: state_nx = SERVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= SERVE;
            cnt         <= CNT_INIT;
            ball_x      <= mid_x;
            ball_y      <= mid_y;
            vel_x       <= V0;
            vel_y       <= V0;
            score_l     <= '0;
            score_r     <= '0;
            score_pulse <= 2'b00;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            ball_x      <= bx_nx;
            ball_y      <= by_nx;
            vel_x       <= vx_nx;
            vel_y       <= vy_nx;
            score_l     <= sl_nx;
            score_r     <= sr_nx;
            score_pulse <= pulse_nx;
        end
    end

    assign serve_active = (state == SERVE);
    assign game_over    = (state == OVER);
endmodule

// File: tb/tb_ball_physics_engine.sv
// Bench for ball_physics_engine: directed table, corner sequences and
// randomized play against an integer reference model (WIN_SCORE=3).
module tb_ball_physics_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        restart = 1'b0;
    logic [15:0] dim_x = 16'd640, dim_y = 16'd480;
    logic [15:0] lpad_x = 16'd10, lpad_y = 16'd190;
    logic [15:0] rpad_x = 16'd620, rpad_y = 16'd0;
    logic [15:0] ball_x, ball_y, vel_x, vel_y;
    logic [7:0]  score_l, score_r;
    logic [1:0]  score_pulse;
    logic        serve_active, game_over;

    ball_physics_engine #(.WIN_SCORE(3)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .restart(restart),
        .dim_x(dim_x), .dim_y(dim_y),
        .lpad_x(lpad_x), .lpad_y(lpad_y),
        .rpad_x(rpad_x), .rpad_y(rpad_y),
        .ball_x(ball_x), .ball_y(ball_y), .vel_x(vel_x), .vel_y(vel_y),
        .score_l(score_l), .score_r(score_r), .score_pulse(score_pulse),
        .serve_active(serve_active), .game_over(game_over)
    );

    always #5 clk = ~clk;

`ifdef BALL_SPEED_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    int errs = 0;
    int checks = 0;

    // Reference model: mode 0=serve, 1=play, 2=over.
    int m_bx, m_by, m_vx, m_vy, m_sl, m_sr, m_pulse, m_cnt, m_mode;

    function automatic int clampi(int v, int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int mini(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_serve(int dir);
        m_bx  = int'(dim_x) / 2;
        m_by  = int'(dim_y) / 2;
        m_vx  = 5 * dir;
        m_vy  = 5;
        m_cnt = 60;
    endtask

    task automatic model_clock(bit ft, bit rs, bit r);
        int nvx, nvy, py;
        bit lz, rz, hit;
        if (!r) begin
            model_serve(1);
            m_sl = 0; m_sr = 0; m_pulse = 0; m_mode = 0;
            return;
        end
        m_pulse = 0;
        if (m_mode == 0 && ft) begin
            m_cnt = m_cnt - 1;
            if (m_cnt <= 0) m_mode = 1;
        end else if (m_mode == 1 && ft) begin
            nvy = m_vy;
            if (m_by <= 10 && m_vy < 0) nvy = -m_vy;
            if (m_by + 15 >= int'(dim_y) && m_vy > 0) nvy = -m_vy;
            lz = (m_vx < 0) && (m_bx < int'(lpad_x) + 13);
            rz = (m_vx > 0) && (m_bx + 15 > int'(rpad_x));
            py = lz ? int'(lpad_y) : int'(rpad_y);
            hit = (m_by + 15 > py) && (m_by < py + 100);
            nvx = m_vx;
            if ((lz || rz) && hit) begin
                if (!RAMP) nvx = -m_vx;
                else if (m_vx < 0) nvx = mini(-m_vx + 1, 15);
                else nvx = -mini(m_vx + 1, 15);
            end
            if ((lz || rz) && !hit) begin
                if (rz) begin
                    m_sl = mini(m_sl + 1, 255);
                    m_pulse = 1;
                    model_serve(1);
                    m_mode = (m_sl >= 3) ? 2 : 0;
                end else begin
                    m_sr = mini(m_sr + 1, 255);
                    m_pulse = 2;
                    model_serve(-1);
                    m_mode = (m_sr >= 3) ? 2 : 0;
                end
            end else begin
                m_vx = nvx;
                m_vy = nvy;
                m_bx = clampi(m_bx + nvx, int'(dim_x) - 1);
                m_by = clampi(m_by + nvy, int'(dim_y) - 1);
            end
        end else if (m_mode == 2 && rs) begin
            model_serve(1);
            m_sl = 0; m_sr = 0; m_mode = 0;
        end
    endtask

    task automatic step(input bit ft, input bit rs, input bit r);
        @(negedge clk);
        frame_tick = ft;
        restart    = rs;
        rst        = r;
        @(posedge clk);
        model_clock(ft, rs, r);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic int svx();
        return int'($signed(vel_x));
    endfunction

    function automatic int svy();
        return int'($signed(vel_y));
    endfunction

    task automatic chk_model();
        chk("rnd_bx", int'(ball_x), m_bx);
        chk("rnd_by", int'(ball_y), m_by);
        chk("rnd_vx", svx(), m_vx);
        chk("rnd_vy", svy(), m_vy);
        chk("rnd_sl", int'(score_l), m_sl);
        chk("rnd_sr", int'(score_r), m_sr);
        chk("rnd_pulse", int'(score_pulse), m_pulse);
        chk("rnd_serve", int'(serve_active), int'(m_mode == 0));
        chk("rnd_over", int'(game_over), int'(m_mode == 2));
    endtask

    task automatic do_reset();
        rpad_y = 16'd0;
        step(0, 0, 0);
        step(0, 0, 0);
    endtask

    task automatic miss_round();
        repeat (118) step(1, 0, 1);
        step(1, 0, 1);
    endtask

    typedef struct {
        int ticks;
        int rpy;
        int bx, by, vx, vy, serve;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{0,  0,   320, 240, 5, 5, 1};
        tbl[1] = '{59, 0,   320, 240, 5, 5, 1};
        tbl[2] = '{1,  0,   320, 240, 5, 5, 0};
        tbl[3] = '{1,  0,   325, 245, 5, 5, 0};
        tbl[4] = '{44, 0,   545, 465, 5, 5, 0};
        tbl[5] = '{1,  0,   550, 460, 5, -5, 0};
        tbl[6] = '{12, 350, 610, 400, 5, -5, 0};
        tbl[7] = '{1,  350, RAMP ? 604 : 605, 395, RAMP ? -6 : -5, -5, 0};

        do_reset();
        foreach (tbl[i]) begin
            rpad_y = 16'(tbl[i].rpy);
            repeat (tbl[i].ticks) begin
                step(1, 0, 1);
                step(0, 0, 1);
            end
            chk($sformatf("tbl%0d_bx", i), int'(ball_x), tbl[i].bx);
            chk($sformatf("tbl%0d_by", i), int'(ball_y), tbl[i].by);
            chk($sformatf("tbl%0d_vx", i), svx(), tbl[i].vx);
            chk($sformatf("tbl%0d_vy", i), svy(), tbl[i].vy);
            chk($sformatf("tbl%0d_serve", i), int'(serve_active),
                tbl[i].serve);
            chk($sformatf("tbl%0d_pulse", i), int'(score_pulse), 0);
        end

        // Right-paddle miss, restart outside OVER, then play to game over.
        do_reset();
        miss_round();
        chk("miss_sl", int'(score_l), 1);
        chk("miss_sr", int'(score_r), 0);
        chk("miss_pulse", int'(score_pulse), 1);
        chk("miss_bx", int'(ball_x), 320);
        chk("miss_by", int'(ball_y), 240);
        chk("miss_vx", svx(), 5);
        chk("miss_vy", svy(), 5);
        chk("miss_serve", int'(serve_active), 1);
        step(0, 0, 1);
        chk("pulse_width", int'(score_pulse), 0);
        step(0, 1, 1);
        chk("restart_ign_sl", int'(score_l), 1);
        chk("restart_ign_serve", int'(serve_active), 1);
        miss_round();
        chk("miss2_sl", int'(score_l), 2);
        chk("miss2_over", int'(game_over), 0);
        miss_round();
        chk("win_sl", int'(score_l), 3);
        chk("win_over", int'(game_over), 1);
        chk("win_serve", int'(serve_active), 0);
        chk("win_pulse", int'(score_pulse), 1);
        chk("win_bx", int'(ball_x), 320);
        repeat (5) step(1, 0, 1);
        chk("over_hold_bx", int'(ball_x), 320);
        chk("over_hold_by", int'(ball_y), 240);
        chk("over_hold_sl", int'(score_l), 3);
        chk("over_hold_flag", int'(game_over), 1);
        step(0, 1, 1);
        chk("restart_sl", int'(score_l), 0);
        chk("restart_over", int'(game_over), 0);
        chk("restart_serve", int'(serve_active), 1);
        chk("restart_vx", svx(), 5);

        // Reset coinciding with the miss tick wins over it.
        do_reset();
        repeat (118) step(1, 0, 1);
        step(1, 0, 0);
        chk("rst_pulse", int'(score_pulse), 0);
        chk("rst_sl", int'(score_l), 0);
        chk("rst_bx", int'(ball_x), 320);
        chk("rst_by", int'(ball_y), 240);
        chk("rst_vx", svx(), 5);
        chk("rst_serve", int'(serve_active), 1);

        // Randomized play against the model.
        do_reset();
        for (int n = 0; n < 12000; n++) begin
            lpad_y = 16'($urandom_range(0, 380));
            rpad_y = 16'($urandom_range(0, 380));
            step($urandom_range(0, 2) != 0, $urandom_range(0, 20) == 0,
                 $urandom_range(0, 1999) != 0);
            chk_model();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
